// File: rtl/sub_share_sched_pkg.sv
// Shared constants and helpers for the sub_share_sched lane scheduler.
package sub_share_pkg;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_TDM = 1'b1;

    // Bit-chain transform on a wide vector; callers keep only the low WD bits,
    // which is exact because bit j only depends on bits j and j-1.
    function automatic logic [31:0] chain_xform(input logic [31:0] s);
        logic [31:0] r;
        r    = 32'd0;
        r[0] = s[0];
        for (int j = 1; j < 32; j++) begin
            r[j] = ~s[j-1] ^ s[j];
        end
        return r;
    endfunction

    function automatic logic [7:0] wrap_inc(input logic [7:0] idx, input logic [7:0] nreq);
        if (idx == nreq - 8'd1) begin
            return 8'd0;
        end else begin
            return idx + 8'd1;
        end
    endfunction

endpackage

// File: rtl/sub_share_sched_if.sv
// Requester/result bus of the shared-transform scheduler.
interface sub_share_sched_if #(
    parameter int NREQ = 5,
    parameter int WD   = 4,
    parameter int IDW  = 3
);
    logic                 MODE;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ*WD-1:0]   REQ_DATA;
    logic [NREQ-1:0]      REQ_READY;
    logic                 OUT_VALID;
    logic [WD-1:0]        OUT_DATA;
    logic [IDW-1:0]       OUT_ID;
    logic                 OUT_READY;

    modport master (
        output MODE, REQ_VALID, REQ_DATA, OUT_READY,
        input  REQ_READY, OUT_VALID, OUT_DATA, OUT_ID
    );

    modport slave (
        input  MODE, REQ_VALID, REQ_DATA, OUT_READY,
        output REQ_READY, OUT_VALID, OUT_DATA, OUT_ID
    );
endinterface

// File: rtl/sub_share_sched_rr_pick.sv
// Rotating priority encoder: nearest valid lane at or after start_idx, with wrap.
module rr_pick #(
    parameter int NREQ = 5,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  start_idx,
    output logic            found,
    output logic [IDW-1:0]  pick_idx
);

    // Pick the valid lane with the smallest forward distance from start_idx.
    always_comb begin
        int best_dist_s;
        int dist_s;
        best_dist_s = NREQ;
        dist_s      = 0;
        found       = 1'b0;
        pick_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i >= int'(start_idx)) begin
                dist_s = i - int'(start_idx);
            end else begin
                dist_s = i + NREQ - int'(start_idx);
            end
            if (req_valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                found       = 1'b1;
                pick_idx    = IDW'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

endmodule

// File: rtl/sub_share_sched.sv
// Shares one bit-chain transform between NREQ lanes, round-robin or TDM,
// with a single registered valid/ready output stage.
module sub_share_sched
    import sub_share_pkg::*;
#(
    parameter int NREQ = 5,
    parameter int WD   = 4,
    parameter int IDW  = 3
) (
    input  logic               CLK,
    input  logic               RST_X,
    sub_share_sched_if.slave   bus
);

    logic [IDW-1:0]  ptr_r;
    logic            out_valid_r;
    logic [WD-1:0]   out_data_r;
    logic [IDW-1:0]  out_id_r;

    logic            can_take_s;
    logic            pick_found_s;
    logic [IDW-1:0]  pick_idx_s;
    logic            acc_s;
    logic [IDW-1:0]  acc_id_s;
    logic [IDW-1:0]  ptr_nxt_s;
    logic [NREQ-1:0] req_ready_s;
    logic [WD-1:0]   sel_data_s;
    logic [WD-1:0]   xf_s;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req_valid (bus.REQ_VALID),
        .start_idx (ptr_r),
        .found     (pick_found_s),
        .pick_idx  (pick_idx_s)
    );

    assign can_take_s = !out_valid_r | bus.OUT_READY;

    // Grant selection and pointer advance for both scheduling modes.
    always_comb begin
        req_ready_s = '0;
        acc_s       = 1'b0;
        acc_id_s    = '0;
        ptr_nxt_s   = ptr_r;
        if (bus.MODE == MODE_RR) begin
            if (can_take_s && pick_found_s) begin
                req_ready_s[pick_idx_s] = 1'b1;
                acc_s                   = 1'b1;
                acc_id_s                = pick_idx_s;
                ptr_nxt_s               = IDW'(wrap_inc(8'(pick_idx_s), 8'(NREQ)));
            end else begin
                ptr_nxt_s = ptr_r;
            end
        end else begin
            // TDM burns the slot even when its lane is idle.
            if (can_take_s) begin
                req_ready_s[ptr_r] = bus.REQ_VALID[ptr_r];
                acc_s              = bus.REQ_VALID[ptr_r];
                acc_id_s           = ptr_r;
                ptr_nxt_s          = IDW'(wrap_inc(8'(ptr_r), 8'(NREQ)));
            end else begin
                ptr_nxt_s = ptr_r;
            end
        end
    end

    // Select the granted lane's word and apply the odd-lane inversion plus chain.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_id_s == IDW'(i)) begin
                sel_data_s = bus.REQ_DATA[i*WD +: WD];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (acc_id_s[0]) begin
            xf_s = WD'(chain_xform(32'(~sel_data_s)));
        end else begin
            xf_s = WD'(chain_xform(32'(sel_data_s)));
        end
    end

    // Output stage and lane pointer.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            ptr_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_id_r    <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
            if (acc_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= xf_s;
                out_id_r    <= acc_id_s;
            end else if (bus.OUT_READY) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.REQ_READY = req_ready_s & {NREQ{RST_X}};
    assign bus.OUT_VALID = out_valid_r;
    assign bus.OUT_DATA  = out_data_r;
    assign bus.OUT_ID    = out_id_r;

endmodule

// File: tb/tb_sub_share_sched.sv
// Directed plus randomized bench for sub_share_sched against a lane-level model.
module tb_sub_share_sched;

    localparam int NREQ = 5;
    localparam int WD   = 4;
    localparam int IDW  = 3;

    logic CLK;
    logic RST_X;
    int   checks;
    int   failures;

    int   m_ptr;
    logic m_ov;
    logic [WD-1:0] m_od;
    int   m_oid;
    int   g_last;

    sub_share_sched_if #(.NREQ(NREQ), .WD(WD), .IDW(IDW)) bus ();

    sub_share_sched #(.NREQ(NREQ), .WD(WD), .IDW(IDW)) dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_oid = 0;
    endtask

    // One clock: drive inputs, compare against the model mid-cycle, advance the model.
    task automatic cyc(input logic mode, input logic [NREQ-1:0] v,
                       input logic [NREQ*WD-1:0] d, input logic ordy);
        logic          ct;
        int            g;
        int            lane;
        logic [WD-1:0] dl;
        logic [WD-1:0] s;
        logic [WD-1:0] r;
        logic [NREQ-1:0] exp_rdy;
        bus.MODE      = mode;
        bus.REQ_VALID = v;
        bus.REQ_DATA  = d;
        bus.OUT_READY = ordy;
        @(negedge CLK);
        ct = !m_ov || ordy;
        g  = -1;
        if (ct) begin
            if (mode == 1'b0) begin
                for (int o = 0; o < NREQ; o++) begin
                    lane = (m_ptr + o) % NREQ;
                    if (g < 0 && v[lane]) g = lane;
                end
            end else if (v[m_ptr]) begin
                g = m_ptr;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 32'(bus.REQ_READY), 32'(exp_rdy));
        chk("out_valid", 32'(bus.OUT_VALID), 32'(m_ov));
        chk("out_data",  32'(bus.OUT_DATA),  32'(m_od));
        chk("out_id",    32'(bus.OUT_ID),    32'(m_oid));
        if (g >= 0) begin
            dl = WD'(d >> (WD * g));
            s  = (g % 2 == 1) ? ~dl : dl;
            r  = s ^ (~s << 1);
            m_ov  = 1'b1;
            m_od  = r;
            m_oid = g;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (mode == 1'b0) begin
            if (g >= 0) m_ptr = (g + 1) % NREQ;
        end else if (ct) begin
            m_ptr = (m_ptr + 1) % NREQ;
        end
        g_last = g;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int rr_exp [6];
        int tdm_cnt;
        logic [WD-1:0]  held_d;
        logic [IDW-1:0] held_id;
        int stall_next;
        checks   = 0;
        failures = 0;
        g_last   = -1;
        rr_exp   = '{0, 1, 2, 3, 4, 0};
        model_reset();

        RST_X         = 1'b0;
        bus.MODE      = 1'b0;
        bus.REQ_VALID = 5'b11111;
        bus.REQ_DATA  = 20'hABCDE;
        bus.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_out_data",  32'(bus.OUT_DATA),  32'd0);
        chk("rst_out_id",    32'(bus.OUT_ID),    32'd0);
        chk("rst_req_ready", 32'(bus.REQ_READY), 32'd0);
        #1 RST_X = 1'b1;

        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);
            chk("rr_order", 32'(g_last), 32'(rr_exp[i]));
        end

        cyc(1'b0, 5'b00001, 20'h00005, 1'b1);
        chk("xf_lane0", 32'(bus.OUT_DATA), 32'(4'b0001));
        cyc(1'b0, 5'b00010, 20'h00050, 1'b1);
        chk("xf_lane1", 32'(bus.OUT_DATA), 32'(4'b0000));
        cyc(1'b0, 5'b00100, 20'h00000, 1'b1);
        chk("xf_lane2", 32'(bus.OUT_DATA), 32'(4'b1110));

        cyc(1'b0, 5'b00010, 20'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 5'b01010, 20'($urandom), 1'b1);
            chk("rr_13_order", 32'(g_last), (i % 2 == 0) ? 32'd3 : 32'd1);
        end

        tdm_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 5'b00100, 20'($urandom), 1'b1);
            if (g_last == 2) tdm_cnt++;
        end
        chk("tdm_accepts", 32'(tdm_cnt), 32'd2);

        cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);
        stall_next = (g_last + 1) % NREQ;
        held_d  = bus.OUT_DATA;
        held_id = bus.OUT_ID;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 5'b11111, 20'($urandom), 1'b0);
            chk("stall_data", 32'(bus.OUT_DATA), 32'(held_d));
            chk("stall_id",   32'(bus.OUT_ID),   32'(held_id));
        end
        cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);
        chk("stall_resume", 32'(g_last), 32'(stall_next));

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom), 5'($urandom), 20'($urandom), ($urandom_range(3, 0) != 0));
        end

        cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);
        chk("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
        #1 RST_X = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("async_rst_ready", 32'(bus.REQ_READY), 32'd0);
        model_reset();
        @(posedge CLK);
        #2 RST_X = 1'b1;
        cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);
        chk("rst_restart_lane0", 32'(g_last), 32'd0);
        cyc(1'b0, 5'b11111, 20'($urandom), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
